// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: instruction width, NOP encoding,
// R/I-type field bit positions and the fetch-queue entry layout.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ir_fifo.sv
// Generic synchronous FIFO with push/pop/flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap by overflow.
module ir_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ir_prefetch_reg.sv
// Instruction register fed by a small prefetch FIFO, with flush and field slicing.
// Define IR_BYPASS_EN to let a push load the IR directly when the FIFO is empty.
module ir_prefetch_reg
  import mips_pkg::*;
#(
  parameter int WIDTH    = INSTR_W,
  parameter int PC_WIDTH = PC_W,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   IRwrite,
  input  logic                   flush,
  output logic [WIDTH-1:0]       data_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   ir_valid,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count,
  output logic [5:0]             opcode,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [4:0]             rd,
  output logic [4:0]             shamt,
  output logic [5:0]             funct,
  output logic [15:0]            imm
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = PC_WIDTH + WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic             push, pop, fifo_push, bypass, fifo_empty;
  logic [ENT_W-1:0] head;
  logic [WIDTH-1:0]    ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;

  assign in_ready   = (count < DEPTH_CNT) && !reset;
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);

`ifdef IR_BYPASS_EN
  assign bypass = push && IRwrite && fifo_empty && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push && !flush && !bypass;
  assign pop       = IRwrite && !fifo_empty && !flush;
  assign stall     = IRwrite && fifo_empty && !flush && !bypass;

  ir_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (fifo_push),
    .pop   (pop),
    .wdata ({pc_in, data_in}),
    .rdata (head),
    .count (count)
  );

  // An IRwrite that finds nothing to load keeps the old word but marks it stale.
  always_comb begin
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      ir_d    = WIDTH'(NOP_INSTR);
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (bypass) begin
      ir_d    = data_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end else if (pop) begin
      ir_d    = head[WIDTH-1:0];
      pc_d    = head[ENT_W-1:WIDTH];
      valid_d = 1'b1;
    end else if (IRwrite) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= WIDTH'(NOP_INSTR);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = ir_q;
  assign pc_out   = pc_q;
  assign ir_valid = valid_q;

  assign opcode = ir_q[OPC_HI:OPC_LO];
  assign rs     = ir_q[RS_HI:RS_LO];
  assign rt     = ir_q[RT_HI:RT_LO];
  assign rd     = ir_q[RD_HI:RD_LO];
  assign shamt  = ir_q[SHAMT_HI:SHAMT_LO];
  assign funct  = ir_q[FUNCT_HI:FUNCT_LO];
  assign imm    = ir_q[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_ir_prefetch_reg.sv
// Directed bench for ir_prefetch_reg (DEPTH=4); expectations follow IR_BYPASS_EN if defined.
module tb_ir_prefetch_reg;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, IRwrite, flush;
  logic [31:0] data_in, pc_in, data_out, pc_out;
  logic        ir_valid, stall;
  logic [2:0]  count;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ir_prefetch_reg #(.WIDTH(32), .PC_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .pc_in(pc_in),
    .in_valid(in_valid), .in_ready(in_ready), .IRwrite(IRwrite), .flush(flush),
    .data_out(data_out), .pc_out(pc_out), .ir_valid(ir_valid), .stall(stall),
    .count(count), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] p,
                       input logic irw, input logic fl);
    in_valid = v;
    data_in  = d;
    pc_in    = p;
    IRwrite  = irw;
    flush    = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic fetch_entry_t ent(input int i);
    fetch_entry_t e;
    e.instr = 32'hA000_0000 + 32'(i);
    e.pc    = 32'h0000_0200 + 32'(4 * i);
    return e;
  endfunction

  fetch_entry_t e;

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 32'h40, 1'b0, 1'b0);
    tick;
    tick;
    check("rst_data_out", data_out, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 0);

    reset = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Basic flow: push then IRwrite
    drive(1'b1, 32'h2109_0004, 32'h100, 1'b0, 1'b0);
    tick;
    check("basic_count_after_push", count, 1);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    tick;
    check("basic_data_out", data_out, 32'h2109_0004);
    check("basic_pc_out", pc_out, 32'h100);
    check("basic_opcode", opcode, 6'h08);
    check("basic_rs", rs, 5'd8);
    check("basic_rt", rt, 5'd9);
    check("basic_imm", imm, 16'h0004);
    check("basic_ir_valid", ir_valid, 1);
    check("basic_count", count, 0);

    // Fill past capacity; words 4 and 5 must be refused
    for (int i = 0; i < 6; i++) begin
      e = ent(i);
      drive(1'b1, e.instr, e.pc, 1'b0, 1'b0);
      #1;
      check($sformatf("full_in_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
      tick;
    end
    check("full_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      e = ent(i);
      drive(1'b0, 0, 0, 1'b1, 1'b0);
      tick;
      check($sformatf("drain_data_%0d", i), data_out, e.instr);
      check($sformatf("drain_pc_%0d", i), pc_out, e.pc);
    end
    check("drain_count", count, 0);

    // Push/pop pairs that cross the pointer wrap
    e = ent(10);
    drive(1'b1, e.instr, e.pc, 1'b0, 1'b0);
    tick;
    for (int i = 11; i < 15; i++) begin
      e = ent(i);
      drive(1'b1, e.instr, e.pc, 1'b1, 1'b0);
      tick;
      e = ent(i - 1);
      check($sformatf("wrap_data_%0d", i), data_out, e.instr);
      check($sformatf("wrap_count_%0d", i), count, 1);
    end
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    tick;
    e = ent(14);
    check("wrap_last_data", data_out, e.instr);
    check("wrap_last_count", count, 0);

    // Simultaneous push/pop at count=2
    for (int i = 20; i < 22; i++) begin
      e = ent(i);
      drive(1'b1, e.instr, e.pc, 1'b0, 1'b0);
      tick;
    end
    check("pp_count_before", count, 2);
    for (int i = 22; i < 24; i++) begin
      e = ent(i);
      drive(1'b1, e.instr, e.pc, 1'b1, 1'b0);
      tick;
      e = ent(i - 2);
      check($sformatf("pp_data_%0d", i), data_out, e.instr);
      check($sformatf("pp_count_%0d", i), count, 2);
    end
    for (int i = 22; i < 24; i++) begin
      drive(1'b0, 0, 0, 1'b1, 1'b0);
      tick;
      e = ent(i);
      check($sformatf("pp_tail_%0d", i), data_out, e.instr);
    end
    check("pp_count_after", count, 0);

    // Empty stall: IR keeps ent(23) but goes invalid
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    #1;
    check("stall_flag", stall, 1);
    tick;
    e = ent(23);
    check("stall_data_hold", data_out, e.instr);
    check("stall_ir_valid", ir_valid, 0);

    // Push and IRwrite together on an empty FIFO
    drive(1'b1, 32'h0000_0020, 32'h300, 1'b1, 1'b0);
    #1;
`ifdef IR_BYPASS_EN
    check("byp_stall", stall, 0);
    tick;
    check("byp_data_out", data_out, 32'h20);
    check("byp_funct", funct, 6'h20);
    check("byp_count", count, 0);
    check("byp_ir_valid", ir_valid, 1);
`else
    check("byp_stall", stall, 1);
    tick;
    check("byp_data_hold", data_out, e.instr);
    check("byp_count", count, 1);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    tick;
    check("byp_late_data", data_out, 32'h20);
    check("byp_late_funct", funct, 6'h20);
    check("byp_late_pc", pc_out, 32'h300);
`endif

    // Flush with push and IRwrite in the same cycle
    for (int i = 30; i < 33; i++) begin
      e = ent(i);
      drive(1'b1, e.instr, e.pc, 1'b0, 1'b0);
      tick;
    end
    check("flush_count_before", count, 3);
    drive(1'b1, 32'hBAD0_0001, 32'h500, 1'b1, 1'b1);
    #1;
    check("flush_stall", stall, 0);
    tick;
    check("flush_count", count, 0);
    check("flush_data_out", data_out, 0);
    check("flush_ir_valid", ir_valid, 0);
    drive(1'b1, 32'h1234_5678, 32'h600, 1'b0, 1'b0);
    tick;
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    tick;
    check("post_flush_data", data_out, 32'h1234_5678);
    check("post_flush_pc", pc_out, 32'h600);
    check("post_flush_count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_reg.md
Name: ir_prefetch_reg

Overview:
Parametrised instruction register with a small prefetch queue in front of it, for the multicycle MIPS datapath.
- Fetched words (with their PC) are pushed into a DEPTH-entry FIFO by the memory side.
- The control unit's IRwrite loads the FIFO head into the architectural IR, which holds otherwise.
- Field slices of the IR feed decode and the register file directly.
- Flush support for branch/jump redirects.

Parameters:
WIDTH, 32, instruction word width (bits)
PC_WIDTH, 32, width of the PC tag stored with each word
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
data_in  in  WIDTH  fetched instruction word
pc_in  in  PC_WIDTH  PC of data_in
in_valid  in  1  data_in/pc_in valid this cycle
in_ready  out  1  FIFO can accept; push = in_valid && in_ready
IRwrite  in  1  request to load next instruction into IR
flush  in  1  discard FIFO contents and invalidate IR
data_out  out  WIDTH  architectural IR contents
pc_out  out  PC_WIDTH  PC of instruction in IR
ir_valid  out  1  data_out holds a real instruction
stall  out  1  IRwrite requested but no instruction available (combinational)
count  out  $clog2(DEPTH)+1  FIFO occupancy
opcode/rs/rt/rd/shamt/funct/imm  out  6/5/5/5/5/6/16  slices of data_out

Behaviour:
Clocking and reset:
- One clock (clk). reset is synchronous, active-high.
- On reset: FIFO emptied, count=0, rd/wr pointers=0, data_out=NOP (32'h0), pc_out=0, ir_valid=0.
- in_ready=0 while reset is high.

FIFO:
- in_ready = (count < DEPTH) && !reset.
- A push writes {pc_in, data_in} at wr_ptr; the word is visible at the head the next cycle (1-cycle fill latency).
- Pop occurs only via an IR load. Pointers wrap modulo DEPTH.
- Push and pop in the same cycle: count unchanged.
- Push when full is impossible because in_ready is low; in_valid is ignored then.

IR load:
- IRwrite && count>0: data_out/pc_out <= head entry, FIFO pops, ir_valid <= 1.
- IRwrite && count==0: IR holds its value, ir_valid <= 0, stall=1 that cycle.
- IRwrite low: IR and ir_valid hold (same hold semantics as the existing IR).
- Latency: push at cycle N, IRwrite at N+1, data_out valid at N+2.

Flush:
- Highest priority after reset: count <= 0, pointers reset, data_out <= NOP, ir_valid <= 0.
- A push or IRwrite in the same cycle is dropped; stall=0 during flush.

Field slices:
- opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0].
- Purely combinational from data_out.

Priority: reset > flush > IRwrite/push.

Optional Feature:
IR_BYPASS_EN
- Defined: when count==0, push and IRwrite happen in the same cycle (no flush), data_in/pc_in load directly into the IR. The FIFO is not written, count stays 0, ir_valid <= 1, stall=0.
- Undefined: that case stalls (stall=1). The pushed word enters the FIFO and is loaded on a later IRwrite.

Decomposition:
Shared package mips_pkg:
- INSTR_W=32, NOP_INSTR=32'h0.
- Field bit-position constants (OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO).
- Struct typedef fetch_entry_t {pc, instr}.
Sub-module:
- ir_fifo: generic synchronous FIFO with push/pop/flush/count, parametrised on width and DEPTH.
- ir_prefetch_reg wraps ir_fifo with the IR register, bypass logic and field slicing.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> data_out=0, ir_valid=0, count=0, in_ready=0; in_ready=1 on the cycle after release.
- Basic flow: push 0x2109_0004@PC 0x100, then IRwrite next cycle -> data_out=0x21090004, pc_out=0x100, opcode=0x08, rs=8, rt=9, imm=4, ir_valid=1, count=0.
- Full/wrap: push 6 words with DEPTH=4 and no IRwrite -> count=4, in_ready=0, words 5–6 rejected; then 4 IRwrites -> words 1–4 in order; then 4 more push/pop pairs cross the wrap point with no corruption.
- Empty stall: IRwrite with count=0 -> stall=1, data_out holds its prior value, ir_valid=0. With IR_BYPASS_EN and a simultaneous push of 0x0000_0020 -> data_out=0x20, funct=0x20, stall=0, count=0.
- Flush: count=3 with flush, push and IRwrite in the same cycle -> next cycle count=0, data_out=0, ir_valid=0; the pushed word is absent from the FIFO.
- Simultaneous push/pop at count=2 -> count stays 2, FIFO order preserved.
